// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract: a BITS-wide carry chain cut into STAGES registered
// segments, with valid/ready handshakes at both ends and signed overflow.
module pipelined_carry_adder #(
    parameter int BITS   = 8,
    parameter int STAGES = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] sum,
    output logic            carry,
    output logic            overflow
);

    localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
    localparam int SEG         = BITS / SAFE_STAGES;
    localparam int LAST        = SAFE_STAGES - 1;

    generate
        if (STAGES < 1 || (BITS % SAFE_STAGES) != 0) begin : g_bad_params
            $error("pipelined_carry_adder: BITS must be a multiple of STAGES and STAGES >= 1");
        end
    endgenerate

    // Per-stage registers: operands travel along so later stages can resolve
    // their upper slices; res_r accumulates the already-resolved low bits.
    logic [SAFE_STAGES-1:0] v_r;
    logic [BITS-1:0]        a_r   [SAFE_STAGES];
    logic [BITS-1:0]        b_r   [SAFE_STAGES];
    logic [BITS-1:0]        res_r [SAFE_STAGES];
    logic [SAFE_STAGES-1:0] c_r;
    logic [SAFE_STAGES-1:0] ovf_r;

    logic [BITS-1:0]        a_in_s   [SAFE_STAGES];
    logic [BITS-1:0]        b_in_s   [SAFE_STAGES];
    logic [BITS-1:0]        res_in_s [SAFE_STAGES];
    logic [BITS-1:0]        res_nx_s [SAFE_STAGES];
    logic [SEG:0]           seg_s    [SAFE_STAGES];
    logic [SAFE_STAGES-1:0] c_in_s;
    logic [SAFE_STAGES-1:0] v_in_s;
    logic [SAFE_STAGES-1:0] c_nx_s;
    logic [SAFE_STAGES-1:0] ovf_nx_s;
    logic [SAFE_STAGES-1:0] adv_s;
    logic                   room_s;

    // Stage inputs: stage 0 takes the ports (with B inverted for subtract), later stages the previous register.
    always_comb begin
        v_in_s      = {SAFE_STAGES{1'b0}};
        c_in_s      = {SAFE_STAGES{1'b0}};
        a_in_s[0]   = A;
        b_in_s[0]   = sub ? ~B : B;
        c_in_s[0]   = cin ^ sub;
        res_in_s[0] = {BITS{1'b0}};
        v_in_s[0]   = in_valid;
        for (int k = 1; k < SAFE_STAGES; k++) begin
            a_in_s[k]   = a_r[k-1];
            b_in_s[k]   = b_r[k-1];
            c_in_s[k]   = c_r[k-1];
            res_in_s[k] = res_r[k-1];
            v_in_s[k]   = v_r[k-1];
        end
    end

    // Segment arithmetic; carry into a segment MSB is recovered as sum ^ a ^ b at that bit.
    always_comb begin
        c_nx_s   = {SAFE_STAGES{1'b0}};
        ovf_nx_s = {SAFE_STAGES{1'b0}};
        for (int k = 0; k < SAFE_STAGES; k++) begin
            seg_s[k] = {1'b0, a_in_s[k][k*SEG +: SEG]}
                     + {1'b0, b_in_s[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, c_in_s[k]};
            res_nx_s[k]                 = res_in_s[k];
            res_nx_s[k][k*SEG +: SEG]   = seg_s[k][SEG-1:0];
            c_nx_s[k]   = seg_s[k][SEG];
            ovf_nx_s[k] = seg_s[k][SEG] ^ (seg_s[k][SEG-1]
                        ^ a_in_s[k][k*SEG+SEG-1] ^ b_in_s[k][k*SEG+SEG-1]);
        end
    end

    // Stage k may load when it or any stage downstream has a hole, or the consumer takes the result.
    always_comb begin
        room_s = out_ready;
        adv_s  = {SAFE_STAGES{1'b0}};
        for (int k = LAST; k >= 0; k--) begin
            room_s   = room_s | ~v_r[k];
            adv_s[k] = room_s;
        end
    end

    // Pipeline registers; data only loads with a valid op so outputs hold through bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_r   <= {SAFE_STAGES{1'b0}};
            c_r   <= {SAFE_STAGES{1'b0}};
            ovf_r <= {SAFE_STAGES{1'b0}};
            for (int k = 0; k < SAFE_STAGES; k++) begin
                a_r[k]   <= {BITS{1'b0}};
                b_r[k]   <= {BITS{1'b0}};
                res_r[k] <= {BITS{1'b0}};
            end
        end else begin
            for (int k = 0; k < SAFE_STAGES; k++) begin
                if (adv_s[k]) begin
                    v_r[k] <= v_in_s[k];
                    if (v_in_s[k]) begin
                        a_r[k]   <= a_in_s[k];
                        b_r[k]   <= b_in_s[k];
                        res_r[k] <= res_nx_s[k];
                        c_r[k]   <= c_nx_s[k];
                        ovf_r[k] <= ovf_nx_s[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = v_r[LAST];
    assign sum       = res_r[LAST];
    assign carry     = c_r[LAST];
    assign overflow  = ovf_r[LAST];

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed bench for pipelined_carry_adder at 8/2, 16/4 and 8/1 configurations.
module tb_pipelined_carry_adder;

    logic clock = 1'b0;
    logic reset_n;

    logic       iv8, ir8, ov8, or8, cin8, sub8, c8, of8;
    logic [7:0] a8, b8, s8;
    logic        iv16, ir16, ov16, or16, cin16, sub16, c16, of16;
    logic [15:0] a16, b16, s16;
    logic       iv1, ir1, ov1, or1, cin1, sub1, c1, of1;
    logic [7:0] a1, b1, s1;

    int checks = 0;
    int errors = 0;

    logic [7:0] sa [16];
    logic [7:0] sb [16];
    logic       sc [16];
    logic       ss [16];
    int         k;

    always #5 clock = ~clock;

    pipelined_carry_adder #(.BITS(8), .STAGES(2)) u8 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8),
        .sum(s8), .carry(c8), .overflow(of8));

    pipelined_carry_adder #(.BITS(16), .STAGES(4)) u16 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16),
        .sum(s16), .carry(c16), .overflow(of16));

    pipelined_carry_adder #(.BITS(8), .STAGES(1)) u1 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1),
        .A(a1), .B(b1), .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .carry(c1), .overflow(of1));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, carry, sum}; overflow from operand/result signs.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic su);
        logic [7:0] be;
        logic [8:0] full;
        logic       ov;
        be   = su ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {8'd0, ci ^ su};
        ov   = (a[7] == be[7]) && (full[7] != a[7]);
        return {ov, full};
    endfunction

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic su);
        a8 = a; b8 = b; cin8 = ci; sub8 = su; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic su, input logic [9:0] exp);
        send8(a, b, ci, su);
        chk({tag, " early"}, 32'(ov8), 32'd0);
        tick();
        chk({tag, " valid"}, 32'(ov8), 32'd1);
        chk(tag, 32'({of8, c8, s8}), 32'(exp));
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic su, input logic [17:0] exp);
        a16 = a; b16 = b; cin16 = ci; sub16 = su; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        tick();
        tick();
        chk({tag, " early"}, 32'(ov16), 32'd0);
        tick();
        chk({tag, " valid"}, 32'(ov16), 32'd1);
        chk(tag, 32'({of16, c16, s16}), 32'(exp));
    endtask

    task automatic op1(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic su, input logic [9:0] exp);
        a1 = a; b1 = b; cin1 = ci; sub1 = su; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        chk({tag, " valid"}, 32'(ov1), 32'd1);
        chk(tag, 32'({of1, c1, s1}), 32'(exp));
    endtask

    initial begin
        reset_n = 1'b0;
        iv8 = 1'b0;  or8 = 1'b1;  a8 = 8'd0;   b8 = 8'd0;   cin8 = 1'b0;  sub8 = 1'b0;
        iv16 = 1'b0; or16 = 1'b1; a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0; sub16 = 1'b0;
        iv1 = 1'b0;  or1 = 1'b1;  a1 = 8'd0;   b1 = 8'd0;   cin1 = 1'b0;  sub1 = 1'b0;

        tick();
        chk("rst out_valid8", 32'(ov8), 32'd0);
        chk("rst result8", 32'({of8, c8, s8}), 32'd0);
        chk("rst out_valid16", 32'(ov16), 32'd0);
        chk("rst out_valid1", 32'(ov1), 32'd0);
        #2 reset_n = 1'b1;
        tick();
        chk("in_ready8 after rst", 32'(ir8), 32'd1);
        chk("in_ready16 after rst", 32'(ir16), 32'd1);
        chk("in_ready1 after rst", 32'(ir1), 32'd1);

        // Directed arithmetic at 8/2
        op8("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
        op8("7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 10'h280);
        op8("80+80", 8'h80, 8'h80, 1'b0, 1'b0, 10'h300);
        op8("05-07", 8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE);
        op8("05-07-1", 8'h05, 8'h07, 1'b1, 1'b1, 10'h0FD);
        tick();
        chk("drained8", 32'(ov8), 32'd0);

        // Back-to-back streaming, one result per cycle
        for (int i = 0; i < 16; i++) begin
            sa[i] = 8'(i * 53 + 7);
            sb[i] = 8'(i * 91 + 200);
            sc[i] = i[0];
            ss[i] = i[1];
        end
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                a8 = sa[i]; b8 = sb[i]; cin8 = sc[i]; sub8 = ss[i]; iv8 = 1'b1;
                chk("stream in_ready", 32'(ir8), 32'd1);
            end else begin
                iv8 = 1'b0;
            end
            tick();
            if (i == 0) begin
                chk("stream first early", 32'(ov8), 32'd0);
            end else begin
                chk("stream valid", 32'(ov8), 32'd1);
                chk("stream result", 32'({of8, c8, s8}),
                    32'(ref8(sa[i-1], sb[i-1], sc[i-1], ss[i-1])));
            end
        end
        tick();
        chk("stream drained", 32'(ov8), 32'd0);

        // Backpressure: consumer stalls for 5 cycles with producer always valid
        k = 0;
        or8 = 1'b0;
        a8 = 8'h90; b8 = 8'h90; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic acc;
            acc = ir8;
            tick();
            if (acc) begin
                k++;
                a8 = 8'(8'h90 + k);
            end
            if (c >= 1) begin
                chk("bp hold", 32'({ov8, of8, c8, s8}),
                    32'({1'b1, ref8(8'h90, 8'h90, 1'b0, 1'b0)}));
            end
        end
        iv8 = 1'b0;
        chk("bp accepted", 32'(k), 32'd2);
        chk("bp in_ready low", 32'(ir8), 32'd0);
        or8 = 1'b1;
        tick();
        chk("bp drain valid", 32'(ov8), 32'd1);
        chk("bp drain op1", 32'({of8, c8, s8}), 32'(ref8(8'h91, 8'h90, 1'b0, 1'b0)));
        tick();
        chk("bp drain empty", 32'(ov8), 32'd0);

        // Reset with two ops in flight
        or8 = 1'b0;
        send8(8'h11, 8'h22, 1'b0, 1'b0);
        send8(8'h33, 8'h44, 1'b0, 1'b0);
        chk("pre-rst valid", 32'(ov8), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async rst valid", 32'(ov8), 32'd0);
        chk("async rst sum", 32'(s8), 32'd0);
        #2 reset_n = 1'b1;
        or8 = 1'b1;
        tick();
        chk("post-rst no stale", 32'(ov8), 32'd0);
        tick();
        chk("post-rst no stale 2", 32'(ov8), 32'd0);
        chk("post-rst in_ready", 32'(ir8), 32'd1);
        op8("post-rst 12+34", 8'h12, 8'h34, 1'b0, 1'b0, 10'h046);
        tick();

        // 16-bit, 4 stages
        op16("16 ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
        op16("16 0005-0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
        tick();
        chk("16 drained", 32'(ov16), 32'd0);

        // 8-bit, single stage
        op1("1 ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
        op1("1 7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 10'h280);
        tick();
        chk("1 drained", 32'(ov1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
Parametrised successor to the combinational clock/A/B/carry/sum adder blocks. Splits a BITS-wide add/subtract into STAGES carry-chain segments, one segment per pipeline register stage. Uses valid/ready handshakes at both ends. Sustains one operation per cycle and adds subtract, carry-in/borrow-in and signed-overflow support. Sits between operand producers and datapath consumers wherever a wide adder would otherwise break timing.

Parameters:
BITS, 8, operand/result width; must be a multiple of STAGES (elaboration error otherwise).
STAGES, 2, number of pipeline stages and carry segments; SEG = BITS/STAGES bits are resolved per stage; STAGES >= 1.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands present.
in_ready  output  1  block can accept this cycle.
A  input  BITS  operand A (unsigned or two's complement).
B  input  BITS  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0 = A+B+cin; 1 = A-B-cin.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts result.
sum  output  BITS  result.
carry  output  1  carry-out (add); NOT-borrow (sub: 1 means no borrow).
overflow  output  1  signed two's-complement overflow.

Behaviour:
- Interface: one clock (clock); reset_n is asynchronous and active-low.
- Reset (reset_n = 0, asynchronous): all stage valid bits, sum, carry and overflow clear to 0; all internal data registers clear to 0; in_ready = 1 from the first cycle after release.
- Arithmetic:
  - At acceptance, B_eff = sub ? ~B : B.
  - c0 = cin XOR sub. For sub with cin=0 this is +1, giving A-B; for cin=1 it is A-B-1.
  - Full result: {carry, sum} = A + B_eff + c0, modulo 2^(BITS+1).
  - overflow = carry into MSB XOR carry out of MSB.
- Pipeline:
  - Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] from the stored A/B_eff slices plus the carry registered by stage k-1 (stage 0 uses c0).
  - Each stage registers its result slice, its carry-out, the already-resolved lower result bits, and the unresolved upper operand slices.
  - The last stage drives sum/carry/overflow directly from registers; no combinational path from A/B to outputs.
- Handshake:
  - Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
  - Stage k advances when it is empty or stage k+1 will accept this cycle. The last stage advances when out_valid=0 or out_ready=1.
  - in_ready = !v0 || stage0_advances. This is combinational from out_ready through the valid chain; no comb path from in_valid to in_ready.
- Latency and throughput:
  - An op accepted at edge t gives out_valid=1 after edge t+STAGES-1 with no stall. With STAGES=1, the result is registered one edge after acceptance.
  - Throughput is 1 op/cycle with out_ready held high; no bubbles are inserted.
- Backpressure:
  - While out_valid && !out_ready, sum/carry/overflow/out_valid hold stable.
  - Upstream stages fill bubbles, then stall. in_ready falls only when all STAGES slots are full.
  - Ordering is strictly FIFO; no op is dropped or duplicated.
- Simultaneous events: full pipeline with out_ready=1 and in_valid=1 accepts and retires in the same cycle; occupancy is unchanged.
- Reset mid-operation discards every in-flight op; out_valid drops immediately (asynchronous).
- Outputs when out_valid=0 hold their last value and must not be sampled.

Test Plan:
- BITS=8, STAGES=2: A=0xFF, B=0x01, sub=0, cin=0 -> sum=0x00, carry=1, overflow=0; out_valid asserted 2 edges after acceptance (tests cross-segment carry).
- BITS=8, STAGES=2, add: A=0x7F+B=0x01 -> sum=0x80, carry=0, overflow=1. A=0x80+B=0x80 -> sum=0x00, carry=1, overflow=1.
- BITS=8, STAGES=2, sub=1, cin=0: A=0x05, B=0x07 -> sum=0xFE, carry=0, overflow=0. Same op with cin=1 -> sum=0xFD.
- Streaming: 16 random ops back-to-back with out_ready=1 -> 16 results in order on 16 consecutive cycles, all matching a reference model.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 ops accepted, then in_ready=0. Outputs stay stable. Release gives in-order drain with no loss.
- Reset mid-stream with 2 ops in flight: assert reset_n=0 -> out_valid=0 immediately, no stale result after release. Repeat the sweep at BITS=16, STAGES=4 (0xFFFF+0x0001 -> 0x0000, carry=1, latency 4) and BITS=8, STAGES=1.
